// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ requesters, with lock support for atomic RMW.
// Optional: define TACHYON_RAM_ARB_DBG_PRIO_EN to give requester 0 (debug) priority in the ARB state.
module ram_port_arbiter #(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ-1:0]                 lock,
   input  logic [NREQ-1:0]                 we,
   input  logic [NREQ*(DATA_WIDTH/8)-1:0]  be,
   input  logic [NREQ*ADDR_WIDTH-1:0]      addr,
   input  logic [NREQ*DATA_WIDTH-1:0]      wdata,
   output logic [NREQ-1:0]                 gnt,
   output logic [NREQ-1:0]                 rvalid,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            locked,
   output logic                            ram_en,
   output logic                            ram_we,
   output logic [DATA_WIDTH/8-1:0]         ram_be,
   output logic [ADDR_WIDTH-3:0]           ram_addr,
   output logic [DATA_WIDTH-1:0]           ram_wdata,
   input  logic [DATA_WIDTH-1:0]           ram_rdata
);

   localparam int BEW   = DATA_WIDTH/8;
   localparam int PTR_W = $clog2(NREQ);
   localparam int WA_W  = ADDR_WIDTH-2;

   typedef enum logic {ARB, LOCK} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [PTR_W-1:0]  win_idx;
   logic              win_found;
   logic [NREQ-1:0]   rvalid_q, rvalid_d;
   logic [2*NREQ-1:0] unused_addr_lsbs;

   function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] i);
      if (int'(i) == NREQ-1) return '0;
      return i + 1'b1;
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_lsbs
      assign unused_addr_lsbs[2*g +: 2] = addr[g*ADDR_WIDTH +: 2];
   end

   // Winner selection: owner only while locked, otherwise first requester scanning from ptr.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      if (state_q == LOCK) begin
         win_found = req[owner_q];
         win_idx   = owner_q;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && req[idx]) begin
               win_found = 1'b1;
               win_idx   = PTR_W'(idx);
            end
         end
`ifdef TACHYON_RAM_ARB_DBG_PRIO_EN
         if (req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
         end
`endif
      end
      if (rst) win_found = 1'b0;
      gnt = '0;
      if (win_found) gnt[win_idx] = 1'b1;
   end

   always_comb begin
      ram_en    = win_found;
      ram_we    = 1'b0;
      ram_be    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (win_found) begin
         ram_we    = we[win_idx];
         ram_be    = be[int'(win_idx)*BEW +: BEW];
         ram_addr  = addr[int'(win_idx)*ADDR_WIDTH + 2 +: WA_W];
         ram_wdata = wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Lock release is decided by the owner's lock bit alone, whether or not it is requesting.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      rvalid_d = gnt & ~we;
      if (state_q == ARB) begin
         if (win_found) begin
            if (lock[win_idx]) begin
               state_d = LOCK;
               owner_d = win_idx;
            end else begin
`ifdef TACHYON_RAM_ARB_DBG_PRIO_EN
               if (win_idx != '0) ptr_d = inc_wrap(win_idx);
`else
               ptr_d = inc_wrap(win_idx);
`endif
            end
         end
      end else begin
         if (!lock[owner_q]) begin
            state_d = ARB;
            ptr_d   = inc_wrap(owner_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB;
         ptr_q    <= '0;
         owner_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = ram_rdata;
   assign locked = (state_q == LOCK);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a small 1-cycle-latency RAM model.
module tb_ram_port_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req, lock, we;
   logic [11:0] be;
   logic [53:0] addr;
   logic [95:0] wdata;
   logic [2:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        locked;
   logic        ramEn, ramWe;
   logic [3:0]  ramBe;
   logic [15:0] ramAddr;
   logic [31:0] ramWdata, ramRdata;
   logic [31:0] mem [0:255];

   int testsRun;
   int testsFailed;

   ram_port_arbiter #(.NREQ(3), .ADDR_WIDTH(18), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .be(be),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .locked(locked), .ram_en(ramEn), .ram_we(ramWe), .ram_be(ramBe),
      .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_rdata(ramRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: byte-enabled write, registered read data one cycle after the strobe.
   always @(posedge clk) begin
      if (ramEn) begin
         if (ramWe) begin
            for (int b = 0; b < 4; b++)
               if (ramBe[b]) mem[ramAddr[7:0]][8*b +: 8] <= ramWdata[8*b +: 8];
         end else begin
            ramRdata <= mem[ramAddr[7:0]];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [2:0] gntExp, input logic [2:0] rvalidExp,
                             input logic lockedExp);
      checkOutput({tag, ".gnt"}, 64'(gnt), 64'(gntExp));
      checkOutput({tag, ".rvalid"}, 64'(rvalid), 64'(rvalidExp));
      checkOutput({tag, ".locked"}, 64'(locked), 64'(lockedExp));
   endtask

   task automatic applyStimulus(input int i, input logic r, input logic w, input logic l,
                                input logic [17:0] a, input logic [31:0] d);
      req[i]            = r;
      we[i]             = w;
      lock[i]           = l;
      be[i*4 +: 4]      = 4'hF;
      addr[i*18 +: 18]  = a;
      wdata[i*32 +: 32] = d;
   endtask

   task automatic clearInputs();
      req = '0; lock = '0; we = '0; be = '0; addr = '0; wdata = '0;
   endtask

   // Called at a negedge; leaves the bench at the following negedge with reset released.
   task automatic doReset();
      clearInputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      ramRdata    = '0;
      for (int m = 0; m < 256; m++) mem[m] = '0;
      clearInputs();
      rst = 1'b1;

      // Reset holds gnt/ram_en low even with every requester asking
      applyStimulus(0, 1, 0, 0, 18'h010, 0);
      applyStimulus(1, 1, 0, 0, 18'h020, 0);
      applyStimulus(2, 1, 0, 0, 18'h030, 0);
      #1;
      checkCycle("rst", 3'b000, 3'b000, 1'b0);
      checkOutput("rst.ram_en", 64'(ramEn), 64'd0);

      // Scenario 1: all three reading continuously
      @(negedge clk);
      rst = 1'b0;
      #1;
`ifdef TACHYON_RAM_ARB_DBG_PRIO_EN
      checkCycle("s1c1", 3'b001, 3'b000, 1'b0);
      nextCycle();
      checkCycle("s1c2", 3'b001, 3'b001, 1'b0);
      nextCycle();
      checkCycle("s1c3", 3'b001, 3'b001, 1'b0);
      checkOutput("s1c3.ram_addr", 64'(ramAddr), 64'h4);
`else
      checkCycle("s1c1", 3'b001, 3'b000, 1'b0);
      checkOutput("s1c1.ram_addr", 64'(ramAddr), 64'h4);
      nextCycle();
      checkCycle("s1c2", 3'b010, 3'b001, 1'b0);
      checkOutput("s1c2.ram_addr", 64'(ramAddr), 64'h8);
      nextCycle();
      checkCycle("s1c3", 3'b100, 3'b010, 1'b0);
      checkOutput("s1c3.ram_addr", 64'(ramAddr), 64'hC);
      nextCycle();
      checkCycle("s1c4", 3'b001, 3'b100, 1'b0);
      checkOutput("s1c4.ram_en", 64'(ramEn), 64'd1);
`endif

      // Scenario 2: data writes 0x100, fetch reads it back
      @(negedge clk);
      doReset();
      applyStimulus(1, 1, 1, 0, 18'h100, 32'hDEADBEEF);
      #1;
      checkCycle("s2c1", 3'b010, 3'b000, 1'b0);
      checkOutput("s2c1.ram_we", 64'(ramWe), 64'd1);
      checkOutput("s2c1.ram_addr", 64'(ramAddr), 64'h40);
      checkOutput("s2c1.ram_wdata", 64'(ramWdata), 64'hDEADBEEF);
      checkOutput("s2c1.ram_be", 64'(ramBe), 64'hF);
      @(negedge clk);
      clearInputs();
      applyStimulus(2, 1, 0, 0, 18'h100, 0);
      #1;
      checkCycle("s2c2", 3'b100, 3'b000, 1'b0);
      checkOutput("s2c2.ram_we", 64'(ramWe), 64'd0);
      checkOutput("s2c2.ram_addr", 64'(ramAddr), 64'h40);
      @(negedge clk);
      clearInputs();
      #1;
      checkCycle("s2c3", 3'b000, 3'b100, 1'b0);
      checkOutput("s2c3.rdata", 64'(rdata), 64'hDEADBEEF);
      checkOutput("s2c3.ram_en", 64'(ramEn), 64'd0);
      checkOutput("s2c3.ram_addr", 64'(ramAddr), 64'h0);

`ifndef TACHYON_RAM_ARB_DBG_PRIO_EN
      // Scenario 3: requester 1 locked read then unlocking write while 0 and 2 wait
      @(negedge clk);
      doReset();
      applyStimulus(0, 1, 0, 0, 18'h010, 0);
      #1;
      checkCycle("s3c1", 3'b001, 3'b000, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1, 0, 1, 18'h020, 0);
      applyStimulus(2, 1, 0, 0, 18'h030, 0);
      #1;
      checkCycle("s3c2", 3'b010, 3'b001, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1, 1, 0, 18'h020, 32'h12345678);
      #1;
      checkCycle("s3c3", 3'b010, 3'b010, 1'b1);
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 18'h020, 0);
      #1;
      checkCycle("s3c4", 3'b100, 3'b000, 1'b0);
      nextCycle();
      checkCycle("s3c5", 3'b001, 3'b100, 1'b0);
`endif

      // Scenario 4: owner idles holding lock, then releases
      @(negedge clk);
      doReset();
      applyStimulus(1, 1, 0, 1, 18'h020, 0);
      #1;
      checkCycle("s4c1", 3'b010, 3'b000, 1'b0);
      @(negedge clk);
      applyStimulus(1, 0, 0, 1, 18'h020, 0);
      applyStimulus(2, 1, 0, 0, 18'h030, 0);
      #1;
      checkCycle("s4idle0", 3'b000, 3'b010, 1'b1);
      for (int c = 1; c < 5; c++) begin
         nextCycle();
         checkCycle($sformatf("s4idle%0d", c), 3'b000, 3'b000, 1'b1);
      end
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 18'h020, 0);
      #1;
      checkCycle("s4rel", 3'b000, 3'b000, 1'b1);
      nextCycle();
      checkCycle("s4next", 3'b100, 3'b000, 1'b0);

      // Scenario 5: async reset while locked with a read return pending
      @(negedge clk);
      doReset();
      applyStimulus(1, 1, 0, 1, 18'h020, 0);
      #1;
      checkCycle("s5c1", 3'b010, 3'b000, 1'b0);
      nextCycle();
      checkCycle("s5c2", 3'b010, 3'b010, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      checkCycle("s5rst", 3'b000, 3'b000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      clearInputs();
      applyStimulus(1, 1, 0, 0, 18'h020, 0);
      applyStimulus(2, 1, 0, 0, 18'h030, 0);
      #1;
      checkCycle("s5c3", 3'b010, 3'b000, 1'b0);
      nextCycle();
      checkCycle("s5c4", 3'b100, 3'b010, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the CPU's single-port RAM (1-cycle read latency) between NREQ requesters: index 0 is JTAG debug, 1 is data load/store, 2 is instruction fetch. The block arbitrates round-robin and drives the RAM port combinationally in the grant cycle. It returns read data one cycle later, qualified per requester. It also supports a lock for atomic read-modify-write sequences. The block sits inside the CPU between the pipeline/debug module and the RAM instance.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_WIDTH, 18, byte address width; the RAM word address is ADDR_WIDTH-2 bits
DATA_WIDTH, 32, data width; the byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  access request per requester
lock  in  NREQ  keep ownership after this access
we  in  NREQ  1=write, 0=read
be  in  NREQ*DATA_WIDTH/8  byte enables, slice i for requester i
addr  in  NREQ*ADDR_WIDTH  byte address, slice i; bits [1:0] ignored
wdata  in  NREQ*DATA_WIDTH  write data, slice i
gnt  out  NREQ  one-hot access accepted this cycle
rvalid  out  NREQ  rdata valid for requester i
rdata  out  DATA_WIDTH  read data, shared bus
locked  out  1  arbiter in LOCK state
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write
ram_be  out  DATA_WIDTH/8  RAM byte enables
ram_addr  out  ADDR_WIDTH-2  RAM word address = addr[ADDR_WIDTH-1:2] of winner
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (async): ptr=0, state=ARB, owner=0, rvalid=0, locked=0. While rst=1, gnt=0 and ram_en=0 regardless of req.
- Handshake: a requester holds req/we/be/addr/wdata/lock stable until it sees gnt. gnt is combinational from req and state, and is at most one-hot. A requester holding req high after gnt makes a new back-to-back request.
- RAM drive: ram_en=|gnt. ram_we/be/addr/wdata are muxed from the winner. When ram_en=0 these outputs are 0.
- Read return: rvalid[i] is registered = gnt[i]&~we[i], so it is high exactly 1 cycle after the grant. rdata=ram_rdata passes through. Writes produce no rvalid.
- Throughput: 1 access per cycle; no bubbles between different requesters.
- FSM ARB: the winner is the first requesting index scanning ptr, ptr+1, ... mod NREQ. On gnt[i]: if lock[i]=1, go to LOCK with owner=i and ptr unchanged; else ptr=(i+1) mod NREQ.
- FSM LOCK: only the owner can be granted; other requests stall (gnt=0) with no time limit. On gnt[owner] with lock=0: go to ARB, ptr=(owner+1) mod NREQ. If owner has req=0 and lock=0: go to ARB with no grant, ptr=(owner+1) mod NREQ. If owner has req=0 and lock=1: stay in LOCK idle.
- lock[i] is ignored when req[i]=0 in ARB.
- No requests: gnt=0, ram_en=0, state/ptr unchanged.
- Reset mid-operation: pending rvalid is dropped, LOCK is abandoned, and the next grant after reset starts from index 0.

Optional Feature:
TACHYON_RAM_ARB_DBG_PRIO_EN
- Defined: in ARB, a request from index 0 (debug) always wins over the round-robin choice. ptr is not advanced on such debug grants. LOCK rules are unchanged, so debug still waits for a foreign lock to release.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then req=3'b111 held, all reads, no lock -> gnt sequence 001,010,100,001 on consecutive cycles. rvalid follows each grant by 1 cycle. ram_addr matches each addr>>2.
- Data requester (1) writes addr=0x100, wdata=0xDEADBEEF, be=4'b1111; then fetch (2) reads 0x100 -> ram_we=1 with ram_addr=0x40 in cycle 1. In cycle 2 fetch is granted. In cycle 3 rvalid=3'b100 and rdata=0xDEADBEEF.
- Requester 1 read with lock=1, then write with lock=0, while 0 and 2 request continuously -> locked=1 for 1 cycle and 0/2 stall. Next grant is to 2 (ptr=2), then 0.
- Owner 1 locks, then drops req with lock=1 for 5 cycles -> gnt=0 for 5 cycles and locked stays 1. Owner drops lock -> ARB, and 2 is granted next cycle.
- Assert rst while in LOCK with a read grant outstanding -> rvalid=0 and locked=0 immediately (async). After release with req=3'b110, gnt=010 first.
- With TACHYON_RAM_ARB_DBG_PRIO_EN, req=3'b111 held -> gnt=001 every cycle. Without the macro -> rotation as in scenario 1.
